// File: rtl/axil_manager.sv
// axil_manager: AXI4-Lite manager that runs one read or write transaction per accepted command.
//
// Command port  : cmd_valid_in/cmd_ready_out handshake with cmd_write_in, cmd_addr_in,
//                 cmd_wdata_in and cmd_wstrb_in.
// Response port : rsp_valid_out/rsp_ready_in handshake with rsp_resp_out (BRESP/RRESP) and
//                 rsp_rdata_out (zero for writes).
// AXI-Lite      : AW, W, B, AR and R channels (axi_*). Only one transaction is outstanding.
// Optional      : define AXIL_MANAGER_WATCHDOG_EN to add the sticky timeout_out flag, which is
//                 set after TIMEOUT_CYCLES cycles in one wait state. It never aborts a transaction.
// All outputs come straight from registers.
module axil_manager #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 4
`ifdef AXIL_MANAGER_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                      axi_aclk_in,
    input  logic                      axi_aresetn_in,
    // command port
    input  logic                      cmd_valid_in,
    output logic                      cmd_ready_out,
    input  logic                      cmd_write_in,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr_in,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata_in,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_in,
    // response port
    output logic                      rsp_valid_out,
    input  logic                      rsp_ready_in,
    output logic [1:0]                rsp_resp_out,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_out,
    // AW channel
    output logic [ADDRESS_WIDTH-1:0]  axi_awaddr_out,
    output logic [2:0]                axi_awprot_out,
    output logic                      axi_awvalid_out,
    input  logic                      axi_awready_in,
    // W channel
    output logic [DATA_WIDTH-1:0]     axi_wdata_out,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb_out,
    output logic                      axi_wvalid_out,
    input  logic                      axi_wready_in,
    // B channel
    input  logic [1:0]                axi_bresp_in,
    input  logic                      axi_bvalid_in,
    output logic                      axi_bready_out,
    // AR channel
    output logic [ADDRESS_WIDTH-1:0]  axi_araddr_out,
    output logic [2:0]                axi_arprot_out,
    output logic                      axi_arvalid_out,
    input  logic                      axi_arready_in,
    // R channel
    input  logic [DATA_WIDTH-1:0]     axi_rdata_in,
    input  logic [1:0]                axi_rresp_in,
    input  logic                      axi_rvalid_in,
    output logic                      axi_rready_out
`ifdef AXIL_MANAGER_WATCHDOG_EN
    ,
    output logic                      timeout_out
`endif
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone
    } state_e;

    state_e                     state_q, state_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       awvalid_q, awvalid_d;
    logic                       wvalid_q, wvalid_d;
    logic                       bready_q, bready_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [1:0]                 rsp_resp_q, rsp_resp_d;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [StrbWidth-1:0]       wstrb_q, wstrb_d;
    logic                       cmd_accept;

    assign cmd_accept = cmd_valid_in && cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr_in;
                    wdata_d     = cmd_wdata_in;
                    wstrb_d     = cmd_wstrb_in;
                    if (cmd_write_in) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                // AW and W complete independently; a low valid means that channel is done.
                awvalid_d = awvalid_q && !axi_awready_in;
                wvalid_d  = wvalid_q && !axi_wready_in;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (axi_bvalid_in && bready_q) begin
                    state_d     = StDone;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = axi_bresp_in;
                    rsp_rdata_d = '0;
                end
            end
            StRdReq: begin
                if (axi_arready_in) begin
                    state_d   = StRdResp;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdResp: begin
                if (axi_rvalid_in && rready_q) begin
                    state_d     = StDone;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = axi_rresp_in;
                    rsp_rdata_d = axi_rdata_in;
                end
            end
            StDone: begin
                if (rsp_ready_in) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_aclk_in or negedge axi_aresetn_in) begin
        if (!axi_aresetn_in) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

`ifdef AXIL_MANAGER_WATCHDOG_EN
    localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TIMEOUT_CYCLES);

    logic [WdWidth-1:0] wd_cnt_q, wd_cnt_d;
    logic               timeout_q, timeout_d;
    logic               wd_wait;

    always_comb begin
        wd_wait   = (state_q == StWrReq) || (state_q == StWrResp) ||
                    (state_q == StRdReq) || (state_q == StRdResp);
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (wd_wait && (wd_cnt_q != WdLimit)) begin
            wd_cnt_d = wd_cnt_q + WdWidth'(1);
        end
        if (wd_wait && (state_d == state_q) && (wd_cnt_d == WdLimit)) begin
            timeout_d = 1'b1;
        end
        if (cmd_accept) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk_in or negedge axi_aresetn_in) begin
        if (!axi_aresetn_in) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`endif

    assign cmd_ready_out   = cmd_ready_q;
    assign rsp_valid_out   = rsp_valid_q;
    assign rsp_resp_out    = rsp_resp_q;
    assign rsp_rdata_out   = rsp_rdata_q;
    assign axi_awaddr_out  = addr_q;
    assign axi_awprot_out  = 3'b000;
    assign axi_awvalid_out = awvalid_q;
    assign axi_wdata_out   = wdata_q;
    assign axi_wstrb_out   = wstrb_q;
    assign axi_wvalid_out  = wvalid_q;
    assign axi_bready_out  = bready_q;
    assign axi_araddr_out  = addr_q;
    assign axi_arprot_out  = 3'b000;
    assign axi_arvalid_out = arvalid_q;
    assign axi_rready_out  = rready_q;

endmodule

// File: doc/axil_manager.md
Name: axil_manager

Overview:
AXI4-Lite manager (initiator) for the register-file subordinates in this codebase. It accepts single read or write commands on a simple valid/ready command port and runs exactly one AXI-Lite transaction per command. It returns status and read data on a valid/ready response port. It sits between a local controller/sequencer and any AXI-Lite subordinate; one transaction is outstanding at a time.

Parameters:
DATA_WIDTH, 32, AXI data width in bits; byte strobe width is DATA_WIDTH/8.
ADDRESS_WIDTH, 4, AXI address width in bits.
TIMEOUT_CYCLES, 16, watchdog threshold in cycles; used only when the optional feature is compiled in.

Ports:
axi_aclk_in  input  1  clock; all logic on rising edge
axi_aresetn_in  input  1  asynchronous, active-low reset
cmd_valid_in  input  1  command offered
cmd_ready_out  output  1  command accepted when cmd_valid_in && cmd_ready_out
cmd_write_in  input  1  1 = write, 0 = read
cmd_addr_in  input  ADDRESS_WIDTH  target byte address
cmd_wdata_in  input  DATA_WIDTH  write data
cmd_wstrb_in  input  DATA_WIDTH/8  write byte strobes
rsp_valid_out  output  1  response available
rsp_ready_in  input  1  response consumed
rsp_resp_out  output  2  BRESP or RRESP of the completed transaction
rsp_rdata_out  output  DATA_WIDTH  read data; 0 for writes
axi_awaddr_out, axi_awprot_out(3), axi_awvalid_out, axi_awready_in  AW channel
axi_wdata_out, axi_wstrb_out(DATA_WIDTH/8), axi_wvalid_out, axi_wready_in  W channel
axi_bresp_in(2), axi_bvalid_in, axi_bready_out  B channel
axi_araddr_out, axi_arprot_out(3), axi_arvalid_out, axi_arready_in  AR channel
axi_rdata_in, axi_rresp_in(2), axi_rvalid_in, axi_rready_out  R channel

Behaviour:
- Reset (asynchronous, immediate):
  - All valid/ready outputs are 0, except cmd_ready_out = 1.
  - rsp_resp_out = 0 and rsp_rdata_out = 0; address/data outputs are 0.
  - FSM goes to IDLE.
  - An in-flight transaction is abandoned and no response is produced.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE. All outputs are registered.
- IDLE:
  - cmd_ready_out = 1.
  - On accept, the command is latched into addr/data/strb registers.
  - Write goes to WR_REQ with axi_awvalid_out = axi_wvalid_out = 1 on the next cycle.
  - Read goes to RD_REQ with axi_arvalid_out = 1 on the next cycle.
  - cmd_ready_out = 0 in every other state.
- WR_REQ:
  - AW and W are tracked independently. Each valid drops the cycle after its own ready is sampled high while valid.
  - Either order and simultaneous completion are all legal.
  - When both are done, go to WR_RESP. axi_bready_out = 1 from entry to WR_RESP.
  - A B handshake seen before both AW and W complete is ignored; this is a protocol violation.
- WR_RESP:
  - On axi_bvalid_in && axi_bready_out, capture bresp and set rsp_rdata = 0.
  - bready drops the next cycle; go to DONE.
- RD_REQ:
  - axi_arvalid_out is held with a stable address until axi_arready_in.
  - Then go to RD_RESP with axi_rready_out = 1.
- RD_RESP: on the R handshake, capture rdata and rresp, drop rready, go to DONE.
- DONE:
  - rsp_valid_out = 1; response fields are held stable until rsp_ready_in.
  - On the handshake, go to IDLE with cmd_ready_out = 1 on the following cycle.
- Stability: valids never deassert before their handshake; payloads never change while valid is high.
- axi_awprot_out = axi_arprot_out = 3'b000.
- Minimum latency against a zero-wait subordinate:
  - Command accept to rsp_valid_out is 3 cycles for a read.
  - A write is 3 cycles plus any subordinate AW/W and B registration delay.
- Response errors (resp ≠ 00) are passed through unchanged; there is no retry.

Optional Feature:
Macro AXIL_MANAGER_WATCHDOG_EN.
- With it: adds output timeout_out (1 bit, sticky) and a cycle counter.
  - The counter clears on every state change and counts while in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - When it reaches TIMEOUT_CYCLES, timeout_out is set.
  - timeout_out clears only on reset or on the next accepted command.
  - The transaction still waits for its handshake; the watchdog never abandons a transaction.
- Without it: no counter and no timeout_out port.

Test Plan:
- Write addr 0x4, data 0xDEADBEEF, strb 0xF to a subordinate that asserts awready/wready together -> one AW+W handshake, rsp_valid_out with rsp_resp_out = 00 and rsp_rdata_out = 0. Then read addr 0x4 -> rsp_rdata_out = 0xDEADBEEF, rsp_resp_out = 00.
- Write with awready 2 cycles before wready -> awvalid drops after its handshake, wvalid stays high until wready; exactly one response.
- Read with rvalid and rresp = 10, rsp_ready_in held low for 5 cycles -> rsp_valid_out, rsp_resp_out = 10 and data stable for all 5 cycles; cmd_ready_out = 0 until the response handshake.
- axi_aresetn_in pulsed low during WR_RESP -> all AXI valids and bready = 0 immediately, cmd_ready_out = 1, no rsp_valid_out afterwards.
- Back-to-back commands with cmd_valid_in held high and rsp_ready_in = 1 -> second command accepted exactly 1 cycle after the first response handshake.
- With AXIL_MANAGER_WATCHDOG_EN, TIMEOUT_CYCLES = 16, bvalid withheld 20 cycles -> timeout_out = 1 after 16 cycles in WR_RESP; response still delivered after bvalid; timeout_out clears on the next accepted command.
